regfile_sb: RTL and testbench

Parametrised successor to the 8-bit, 7-register CPU register file. It provides one write port and two combinational read ports, with register 0 hardwired to zero and write-to-read bypass. It also keeps a per-register scoreboard of pending writes, so the decode stage can detect RAW hazards and stall. It sits between decode (reads, reservations) and writeback (writes) in the pipelined core. A debug tap exposes one selected register to board I/O.

---
 rtl/regfile_sb.sv | 110 +++++++++++
 tb/tb_regfile_sb.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb -- CPU register file with write-to-read bypass and a
// single-bit-per-register scoreboard for RAW hazard detection.
//
// Entry 0 reads as zero and is never busy. One write port (writeback), two
// combinational read ports (decode), a reservation port (decode issue) and
// a registered debug tap of one fixed register.
//
// Ports:
//   clk_i, rst_i                       clock, async active-high reset
//   wr_en_i, wr_addr_i, wr_data_i      writeback write port
//   rd_en_i, rd_addr_a_i, rd_addr_b_i  read enable and read addresses
//   use_a_i, use_b_i                   decode consumes operand A / B
//   rsv_en_i, rsv_addr_i               reserve a destination register
//   rd_a_o, rd_b_o                     read data (bypassed)
//   busy_a_o, busy_b_o                 operand has a pending write
//   stall_o                            RAW hazard, decode must hold
//   dbg_o                              registered copy of reg[DBG_REG]
module regfile_sb #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3,
  parameter int DBG_REG = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_a_i,
  input  logic [ADDR_W-1:0] rd_addr_b_i,
  input  logic              use_a_i,
  input  logic              use_b_i,
  input  logic              rsv_en_i,
  input  logic [ADDR_W-1:0] rsv_addr_i,
  output logic [DATA_W-1:0] rd_a_o,
  output logic [DATA_W-1:0] rd_b_o,
  output logic              busy_a_o,
  output logic              busy_b_o,
  output logic              stall_o,
  output logic [DATA_W-1:0] dbg_o
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] DBG_IDX = ADDR_W'(DBG_REG);

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;
  logic [DATA_W-1:0] dbg_p1;
  logic              wr_hit;

  assign wr_hit = wr_en_i && (wr_addr_i != '0);

  // Read priority: disabled / r0 -> zero, same-cycle write -> bypass, else stored.
  function automatic logic [DATA_W-1:0] read_mux(
    input logic              en,
    input logic [ADDR_W-1:0] addr,
    input logic              wen,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata,
    input logic [DATA_W-1:0] stored
  );
    if (!en || addr == '0) return '0;
    if (wen && waddr == addr) return wdata;
    return stored;
  endfunction

  // A writeback in the same cycle resolves the hazard, matching the bypass.
  function automatic logic busy_mux(
    input logic              pending,
    input logic              wen,
    input logic [ADDR_W-1:0] waddr,
    input logic [ADDR_W-1:0] addr
  );
    return pending & ~(wen & (waddr == addr));
  endfunction

  // Clear on write first, then set on reserve so a same-edge reserve wins:
  // the newly issued producer is still outstanding.
  always_comb begin
    busy_nxt = busy;
    if (wr_en_i) busy_nxt[wr_addr_i] = 1'b0;
    if (rsv_en_i) busy_nxt[rsv_addr_i] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // ---- stage p1: register file, scoreboard and debug tap ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      busy   <= '0;
      dbg_p1 <= '0;
    end else begin
      if (wr_hit) regs[wr_addr_i] <= wr_data_i;
      busy   <= busy_nxt;
      // Samples the stored value, so the tap lags the reads by one cycle.
      dbg_p1 <= regs[DBG_IDX];
    end
  end

  assign rd_a_o   = read_mux(rd_en_i, rd_addr_a_i, wr_en_i, wr_addr_i, wr_data_i,
                             regs[rd_addr_a_i]);
  assign rd_b_o   = read_mux(rd_en_i, rd_addr_b_i, wr_en_i, wr_addr_i, wr_data_i,
                             regs[rd_addr_b_i]);
  assign busy_a_o = busy_mux(busy[rd_addr_a_i], wr_en_i, wr_addr_i, rd_addr_a_i);
  assign busy_b_o = busy_mux(busy[rd_addr_b_i], wr_en_i, wr_addr_i, rd_addr_b_i);
  assign stall_o  = rd_en_i & ((use_a_i & busy_a_o) | (use_b_i & busy_b_o));
  assign dbg_o    = dbg_p1;

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 0, rd_en = 0, use_a = 0, use_b = 0, rsv_en = 0;
  logic [2:0] wr_addr = 0, ra = 0, rb = 0, rsv_addr = 0;
  logic [7:0] wr_data = 0;
  logic [7:0] rd_a, rd_b, dbg;
  logic       busy_a, busy_b, stall;

  // 16-bit / 16-entry build
  logic        w_wr_en = 0, w_rd_en = 0, w_use_a = 0, w_use_b = 0, w_rsv_en = 0;
  logic [3:0]  w_wr_addr = 0, w_ra = 0, w_rb = 0, w_rsv_addr = 0;
  logic [15:0] w_wr_data = 0;
  logic [15:0] w_rd_a, w_rd_b, w_dbg;
  logic        w_busy_a, w_busy_b, w_stall;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [7:0] m_reg [8];
  bit         m_busy [8];
  logic [7:0] m_dbg;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(8), .ADDR_W(3), .DBG_REG(3)) dut (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_en_i(rd_en), .rd_addr_a_i(ra), .rd_addr_b_i(rb), .use_a_i(use_a), .use_b_i(use_b),
    .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .rd_a_o(rd_a), .rd_b_o(rd_b),
    .busy_a_o(busy_a), .busy_b_o(busy_b), .stall_o(stall), .dbg_o(dbg));

  regfile_sb #(.DATA_W(16), .ADDR_W(4), .DBG_REG(15)) dut16 (
    .clk_i(clk), .rst_i(rst), .wr_en_i(w_wr_en), .wr_addr_i(w_wr_addr), .wr_data_i(w_wr_data),
    .rd_en_i(w_rd_en), .rd_addr_a_i(w_ra), .rd_addr_b_i(w_rb), .use_a_i(w_use_a),
    .use_b_i(w_use_b), .rsv_en_i(w_rsv_en), .rsv_addr_i(w_rsv_addr), .rd_a_o(w_rd_a),
    .rd_b_o(w_rd_b), .busy_a_o(w_busy_a), .busy_b_o(w_busy_b), .stall_o(w_stall),
    .dbg_o(w_dbg));

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin m_reg[i] = 8'h00; m_busy[i] = 0; end
    m_dbg = 8'h00;
  endtask

  task automatic idle();
    wr_en = 0; rd_en = 0; use_a = 0; use_b = 0; rsv_en = 0;
    wr_addr = 0; ra = 0; rb = 0; rsv_addr = 0; wr_data = 0;
  endtask

  // Advance one clock; update the reference from the inputs seen at the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      m_dbg = m_reg[3];
      if (wr_en && wr_addr != 0) begin m_reg[wr_addr] = wr_data; m_busy[wr_addr] = 0; end
      if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    idle();
    rd_en = 1; ra = 3; rb = 2; use_a = 1; use_b = 1;
    #2;
    checks++; if (rd_a !== 8'h00) begin errors++; $display("FAIL reset_rd_a got %h exp 00", rd_a); end
    checks++; if (rd_b !== 8'h00) begin errors++; $display("FAIL reset_rd_b got %h exp 00", rd_b); end
    checks++; if ({busy_a, busy_b, stall} !== 3'b000) begin errors++; $display("FAIL reset_busy got %b exp 000", {busy_a, busy_b, stall}); end
    checks++; if (dbg !== 8'h00) begin errors++; $display("FAIL reset_dbg got %h exp 00", dbg); end
    rst = 0;
    idle();
    wr_en = 1; wr_addr = 3; wr_data = 8'h5A; rsv_en = 1; rsv_addr = 2;
    tick();
    idle();
    rd_en = 1; ra = 3; rb = 2; use_b = 1;
    tick();
    checks++; if (rd_a !== 8'h5A) begin errors++; $display("FAIL pre_rst_rd_a got %h exp 5a", rd_a); end
    checks++; if (dbg !== 8'h5A) begin errors++; $display("FAIL pre_rst_dbg got %h exp 5a", dbg); end
    checks++; if ({busy_b, stall} !== 2'b11) begin errors++; $display("FAIL pre_rst_busy got %b exp 11", {busy_b, stall}); end
    #2 rst = 1;
    #1;
    model_reset();
    checks++; if (rd_a !== 8'h00) begin errors++; $display("FAIL async_rst_rd_a got %h exp 00", rd_a); end
    checks++; if (dbg !== 8'h00) begin errors++; $display("FAIL async_rst_dbg got %h exp 00", dbg); end
    checks++; if ({busy_b, stall} !== 2'b00) begin errors++; $display("FAIL async_rst_busy got %b exp 00", {busy_b, stall}); end
    #1 rst = 0;
    idle();
    tick();
  endtask

  task automatic test_write_read();
    idle();
    wr_en = 1; wr_addr = 1; wr_data = 8'hA5;
    tick();
    wr_addr = 0; wr_data = 8'h3C;
    tick();
    idle();
    rd_en = 1; ra = 1; rb = 0;
    #1;
    checks++; if (rd_a !== 8'hA5) begin errors++; $display("FAIL rd_r1 got %h exp a5", rd_a); end
    checks++; if (rd_b !== 8'h00) begin errors++; $display("FAIL rd_r0 got %h exp 00", rd_b); end
    rd_en = 0;
    #1;
    checks++; if ({rd_a, rd_b} !== 16'h0000) begin errors++; $display("FAIL rd_disabled got %h exp 0000", {rd_a, rd_b}); end
    tick();
  endtask

  task automatic test_bypass();
    idle();
    wr_en = 1; wr_addr = 5; wr_data = 8'h11;
    tick();
    wr_data = 8'h77; rd_en = 1; ra = 5; rb = 5;
    #1;
    checks++; if (rd_a !== 8'h77) begin errors++; $display("FAIL bypass_a got %h exp 77", rd_a); end
    checks++; if (rd_b !== 8'h77) begin errors++; $display("FAIL bypass_b got %h exp 77", rd_b); end
    checks++; if (dbg !== 8'h00) begin errors++; $display("FAIL bypass_dbg got %h exp 00", dbg); end
    tick();
    wr_en = 0;
    #1;
    checks++; if (rd_a !== 8'h77) begin errors++; $display("FAIL after_bypass got %h exp 77", rd_a); end
    tick();
  endtask

  task automatic test_hazard();
    idle();
    rsv_en = 1; rsv_addr = 2;
    tick();
    idle();
    rd_en = 1; ra = 2; use_a = 1;
    #1;
    checks++; if ({busy_a, stall} !== 2'b11) begin errors++; $display("FAIL hazard got %b exp 11", {busy_a, stall}); end
    use_a = 0;
    #1;
    checks++; if ({busy_a, stall} !== 2'b10) begin errors++; $display("FAIL hazard_nouse got %b exp 10", {busy_a, stall}); end
    rd_en = 0; use_a = 1;
    #1;
    checks++; if ({busy_a, stall} !== 2'b10) begin errors++; $display("FAIL hazard_rd_off got %b exp 10", {busy_a, stall}); end
    rd_en = 1; wr_en = 1; wr_addr = 2; wr_data = 8'h42;
    #1;
    checks++; if ({busy_a, stall} !== 2'b00) begin errors++; $display("FAIL wb_clears got %b exp 00", {busy_a, stall}); end
    checks++; if (rd_a !== 8'h42) begin errors++; $display("FAIL wb_bypass got %h exp 42", rd_a); end
    tick();
    wr_en = 0;
    #1;
    checks++; if ({busy_a, stall} !== 2'b00) begin errors++; $display("FAIL wb_cleared got %b exp 00", {busy_a, stall}); end
    tick();
  endtask

  task automatic test_same_edge();
    idle();
    rsv_en = 1; rsv_addr = 4;
    tick();
    wr_en = 1; wr_addr = 4; wr_data = 8'h99;
    tick();
    idle();
    rd_en = 1; rb = 4; use_b = 1;
    #1;
    checks++; if (rd_b !== 8'h99) begin errors++; $display("FAIL same_edge_data got %h exp 99", rd_b); end
    checks++; if ({busy_b, stall} !== 2'b11) begin errors++; $display("FAIL same_edge_busy got %b exp 11", {busy_b, stall}); end
    wr_en = 1; wr_addr = 4; wr_data = 8'h98;
    tick();
    idle();
  endtask

  task automatic test_random();
    logic [7:0] e_a, e_b;
    bit         e_ba, e_bb, e_st;
    for (int n = 0; n < 400; n++) begin
      wr_en = ($urandom_range(0, 2) != 0); wr_addr = 3'($urandom); wr_data = 8'($urandom);
      rd_en = ($urandom_range(0, 3) != 0); ra = 3'($urandom); rb = 3'($urandom);
      use_a = 1'($urandom); use_b = 1'($urandom);
      rsv_en = ($urandom_range(0, 2) == 0); rsv_addr = 3'($urandom);
      #1;
      e_a  = !rd_en || ra == 0 ? 8'h00 : (wr_en && wr_addr == ra) ? wr_data : m_reg[ra];
      e_b  = !rd_en || rb == 0 ? 8'h00 : (wr_en && wr_addr == rb) ? wr_data : m_reg[rb];
      e_ba = m_busy[ra] && !(wr_en && wr_addr == ra);
      e_bb = m_busy[rb] && !(wr_en && wr_addr == rb);
      e_st = rd_en && ((use_a && e_ba) || (use_b && e_bb));
      checks++; if (rd_a !== e_a) begin errors++; $display("FAIL rand_rd_a n=%0d got %h exp %h", n, rd_a, e_a); end
      checks++; if (rd_b !== e_b) begin errors++; $display("FAIL rand_rd_b n=%0d got %h exp %h", n, rd_b, e_b); end
      checks++; if ({busy_a, busy_b, stall} !== {e_ba, e_bb, e_st}) begin errors++; $display("FAIL rand_busy n=%0d got %b exp %b", n, {busy_a, busy_b, stall}, {e_ba, e_bb, e_st}); end
      checks++; if (dbg !== m_dbg) begin errors++; $display("FAIL rand_dbg n=%0d got %h exp %h", n, dbg, m_dbg); end
      tick();
    end
    idle();
  endtask

  task automatic test_wide();
    w_wr_en = 1; w_wr_addr = 4'd15; w_wr_data = 16'hBEEF;
    @(posedge clk); #1;
    w_wr_en = 0; w_rd_en = 1; w_rb = 4'd15;
    #1;
    checks++; if (w_rd_b !== 16'hBEEF) begin errors++; $display("FAIL wide_rd_b got %h exp beef", w_rd_b); end
    w_rsv_en = 1; w_rsv_addr = 4'd0;
    @(posedge clk); #1;
    w_rsv_en = 0; w_rb = 4'd0; w_use_b = 1;
    #1;
    checks++; if ({w_busy_b, w_stall} !== 2'b00) begin errors++; $display("FAIL wide_r0_busy got %b exp 00", {w_busy_b, w_stall}); end
    checks++; if (w_rd_b !== 16'h0000) begin errors++; $display("FAIL wide_r0_data got %h exp 0000", w_rd_b); end
    checks++; if (w_dbg !== 16'hBEEF) begin errors++; $display("FAIL wide_dbg got %h exp beef", w_dbg); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_hazard();
    test_same_edge();
    test_random();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
